// File: rtl/uart_tx_fifo.sv
// TX byte queue feeding the UART core; optional UART_TXF_OVERFLOW_EN adds a sticky dropped-push flag.
// Latency: byte pushed into an empty queue on an idle line launches (transmit_o) two edges later.
// Backpressure: pushes while full_o are dropped; launches wait for an idle line and the previous byte.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2    = 4,
    parameter int START_TIMEOUT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push_i,
    input  logic [7:0]          push_data_i,
    input  logic                flush_i,
    output logic                full_o,
    output logic                empty_o,
    output logic [DEPTH_LOG2:0] level_o,
    output logic                busy_o,
    output logic                transmit_o,
    output logic [7:0]          tx_byte_o,
`ifdef UART_TXF_OVERFLOW_EN
    input  logic                overflow_clr_i,
    output logic                overflow_o,
`endif
    input  logic                is_transmitting_i
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE} state_t;

    state_t                state_q, state_d;
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  full_q, empty_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  transmit_q;
    logic [7:0]            tx_byte_q;
    logic                  push_acc, pop;

    assign push_acc = push_i && !full_q;
    // Flush suppresses the launch so a flushed head byte can never escape.
    assign pop      = (state_q == IDLE) && !empty_q && !is_transmitting_i && !flush_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (push_acc) wptr_d = wptr_q + DEPTH_LOG2'(1);
            if (pop)      rptr_d = rptr_q + DEPTH_LOG2'(1);
            if (push_acc && !pop)      level_d = level_q + (DEPTH_LOG2+1)'(1);
            else if (pop && !push_acc) level_d = level_q - (DEPTH_LOG2+1)'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:       if (pop) state_d = LAUNCH;
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (is_transmitting_i) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == CW'(START_TIMEOUT)) state_d = IDLE;
                end
            end
            WAIT_DONE:  if (!is_transmitting_i) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wptr_q] <= push_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            cnt_q      <= '0;
            transmit_q <= 1'b0;
            tx_byte_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            full_q     <= (level_d == (DEPTH_LOG2+1)'(DEPTH));
            empty_q    <= (level_d == '0);
            cnt_q      <= cnt_d;
            transmit_q <= (state_d == LAUNCH);
            if (pop) tx_byte_q <= mem_q[rptr_q];
        end
    end

`ifdef UART_TXF_OVERFLOW_EN
    logic overflow_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  overflow_q <= 1'b0;
        else if (push_i && full_q)   overflow_q <= 1'b1;
        else if (overflow_clr_i)     overflow_q <= 1'b0;
    end
    assign overflow_o = overflow_q;
`endif

    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign level_o    = level_q;
    assign busy_o     = !empty_q || (state_q != IDLE);
    assign transmit_o = transmit_q;
    assign tx_byte_o  = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised and directed bench for uart_tx_fifo against a transaction-level queue model.
module tb_uart_tx_fifo;
    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int TO    = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic push = 1'b0, flush = 1'b0;
    logic [7:0] pdata = 8'h00;
    logic tx_man = 1'b0, core_en = 1'b0, core_tx = 1'b0;
    logic is_tx;
    logic full, empty, busy, transmit;
    logic [DL:0] level;
    logic [7:0] tx_byte;
`ifdef UART_TXF_OVERFLOW_EN
    logic ovf_clr = 1'b0, ovf;
`endif

    assign is_tx = core_en ? core_tx : tx_man;

    uart_tx_fifo #(.DEPTH_LOG2(DL), .START_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .push_i(push), .push_data_i(pdata), .flush_i(flush),
        .full_o(full), .empty_o(empty), .level_o(level), .busy_o(busy),
        .transmit_o(transmit), .tx_byte_o(tx_byte),
`ifdef UART_TXF_OVERFLOW_EN
        .overflow_clr_i(ovf_clr), .overflow_o(ovf),
`endif
        .is_transmitting_i(is_tx)
    );

    always #5 clk = ~clk;

    // Reference model: a byte queue plus an abstract "byte in flight" record.
    logic [7:0] q [$];
    bit   m_pulse = 0, m_inflight = 0, m_started = 0, m_ovf = 0;
    int   m_wait = 0;
    logic [7:0] m_byte = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        bit full_now, can_pop;
        if (!rst_n) begin
            q.delete();
            m_pulse = 0; m_inflight = 0; m_started = 0; m_wait = 0;
            m_byte = 8'h00; m_ovf = 0;
        end else begin
            full_now = (q.size() == DEPTH);
            can_pop  = !m_inflight && q.size() != 0 && !is_tx && !flush;
            if (m_pulse) begin
                m_pulse = 0; m_started = 0; m_wait = 0;
            end else if (m_inflight) begin
                if (!m_started) begin
                    if (is_tx) m_started = 1;
                    else begin
                        m_wait++;
                        if (m_wait == TO) m_inflight = 0;
                    end
                end else if (!is_tx) m_inflight = 0;
            end
            if (can_pop) begin
                m_byte = q.pop_front();
                m_pulse = 1; m_inflight = 1;
            end
            if (push && !full_now) q.push_back(pdata);
            if (flush) q.delete();
            if (push && full_now) m_ovf = 1;
`ifdef UART_TXF_OVERFLOW_EN
            else if (ovf_clr) m_ovf = 0;
`endif
        end
    end

    // Simple UART core stand-in: random start delay and busy length after each pulse.
    int c_dly = 0, c_len = 0;
    always @(negedge clk) begin
        if (!core_en) begin
            core_tx = 0; c_dly = 0; c_len = 0;
        end else begin
            if (transmit === 1'b1) begin
                c_dly = $urandom_range(0, 6);
                c_len = $urandom_range(1, 8);
            end
            if (c_dly > 0) begin core_tx = 0; c_dly--; end
            else if (c_len > 0) begin core_tx = 1; c_len--; end
            else core_tx = 0;
        end
    end

    int checks = 0, failures = 0;
    int pulses = 0, cyc = 0;
    logic [7:0] emitted [$];
    int pulse_cyc [$];

    task automatic chk(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // Advance one cycle: compare DUT to model on the falling edge, then drive at +1.
    task automatic step();
        bit bad;
        @(negedge clk);
        cyc++;
        checks++;
        bad = (transmit !== m_pulse) || (tx_byte !== m_byte) || (level !== (DL+1)'(q.size())) ||
              (full !== (q.size() == DEPTH)) || (empty !== (q.size() == 0)) ||
              (busy !== (q.size() != 0 || m_inflight));
`ifdef UART_TXF_OVERFLOW_EN
        if (ovf !== m_ovf) bad = 1;
`endif
        if (bad) begin
            failures++;
            $display("FAIL model_cmp t=%0t got tx=%0b byte=%02h lvl=%0d full=%0b empty=%0b busy=%0b expected tx=%0b byte=%02h lvl=%0d busy=%0b",
                     $time, transmit, tx_byte, level, full, empty, busy,
                     m_pulse, m_byte, q.size(), (q.size() != 0 || m_inflight));
        end
        if (transmit === 1'b1) begin
            pulses++;
            emitted.push_back(tx_byte);
            pulse_cyc.push_back(cyc);
        end
        #1;
    endtask

    initial begin
        int p0;
        step();
        chk("rst_level", int'(level), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_transmit", int'(transmit), 0);
        rst_n = 1;
        step();

        // Single byte latency and busy release.
        push = 1; pdata = 8'h41;
        step();
        push = 0;
        step();
        chk("t1_pulse", int'(transmit), 1);
        chk("t1_byte", int'(tx_byte), 8'h41);
        step();
        chk("t1_pulse_width", int'(transmit), 0);
        tx_man = 1;
        repeat (10) step();
        chk("t1_busy_during", int'(busy), 1);
        tx_man = 0;
        step();
        chk("t1_busy_after", int'(busy), 0);
        chk("t1_pulse_count", pulses, 1);

        // Fill while line busy, overflow, then ordered drain.
        tx_man = 1;
        for (int i = 0; i < 16; i++) begin
            push = 1; pdata = 8'(8'h10 + i);
            step();
        end
        push = 0;
        chk("t2_level16", int'(level), 16);
        chk("t2_full", int'(full), 1);
        push = 1; pdata = 8'hAA;
        step();
        push = 0;
        step();
        chk("t2_level_after_drop", int'(level), 16);
`ifdef UART_TXF_OVERFLOW_EN
        chk("t2_ovf_set", int'(ovf), 1);
        step();
        chk("t2_ovf_sticky", int'(ovf), 1);
        ovf_clr = 1;
        step();
        ovf_clr = 0;
        step();
        chk("t2_ovf_clr", int'(ovf), 0);
`endif
        emitted.delete();
        tx_man = 0; core_en = 1;
        for (int k = 0; k < 600 && busy; k++) step();
        chk("t2_drain_done", int'(busy), 0);
        chk("t2_emit_count", emitted.size(), 16);
        for (int i = 0; i < 16 && i < emitted.size(); i++)
            chk("t2_order", int'(emitted[i]), 8'h10 + i);
        core_en = 0;
        step();

        // Flush during the first launch pulse.
        p0 = pulses;
        push = 1; pdata = 8'h51; step();
        pdata = 8'h52; step();
        chk("t4_launch", int'(transmit), 1);
        pdata = 8'h53; flush = 1; step();
        push = 0; flush = 0;
        repeat (20) step();
        chk("t4_level", int'(level), 0);
        chk("t4_pulses", pulses - p0, 1);
        chk("t4_byte", int'(emitted[emitted.size()-1]), 8'h51);
        chk("t4_idle", int'(busy), 0);

        // Start timeout: line never goes busy.
        pulse_cyc.delete(); emitted.delete();
        push = 1; pdata = 8'h61; step();
        pdata = 8'h62; step();
        push = 0;
        repeat (20) step();
        chk("t5_pulses", pulse_cyc.size(), 2);
        if (pulse_cyc.size() == 2) chk("t5_gap", pulse_cyc[1] - pulse_cyc[0], 6);
        if (emitted.size() == 2) chk("t5_second", int'(emitted[1]), 8'h62);

        // Reset in mid-transmission with bytes queued.
        push = 1; pdata = 8'h71; step();
        push = 0; step();
        chk("t6_pulse", int'(transmit), 1);
        tx_man = 1;
        for (int i = 0; i < 5; i++) begin
            push = 1; pdata = 8'(8'h72 + i); step();
        end
        push = 0;
        chk("t6_level5", int'(level), 5);
        rst_n = 0;
        #1;
        chk("t6_rst_transmit", int'(transmit), 0);
        chk("t6_rst_byte", int'(tx_byte), 0);
        chk("t6_rst_level", int'(level), 0);
        chk("t6_rst_empty", int'(empty), 1);
        chk("t6_rst_busy", int'(busy), 0);
        step(); step();
        rst_n = 1; tx_man = 0;
        p0 = pulses;
        repeat (20) step();
        chk("t6_no_pulse", pulses - p0, 0);

        // Random traffic checked against the model every cycle.
        for (int n = 0; n < 4000; n++) begin
            push  = ($urandom_range(0, 99) < 40);
            pdata = 8'($urandom);
            flush = ($urandom_range(0, 99) < 2);
            if (n % 250 == 0) core_en = $urandom_range(0, 1);
            if ($urandom_range(0, 99) < 10) tx_man = ~tx_man;
`ifdef UART_TXF_OVERFLOW_EN
            ovf_clr = ($urandom_range(0, 99) < 5);
`endif
            if ($urandom_range(0, 999) < 3) rst_n = 0;
            else rst_n = 1;
            step();
        end
        rst_n = 1; push = 0; flush = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
